// File: rtl/uart_frame_decoder_if.sv
// Byte-stream input, frame handshake and payload read port of the UART frame decoder.
// The master side is the UART receiver plus the frame consumer; the decoder is the slave.
interface uart_frame_decoder_if #(
    parameter int MAX_PAYLOAD = 16,
    parameter int LW          = $clog2(MAX_PAYLOAD + 1),
    parameter int AW          = $clog2(MAX_PAYLOAD)
);
    logic          byteValid;
    logic [7:0]    byteIn;
    logic          byteErr;
    logic          frameValid;
    logic          frameAck;
    logic [LW-1:0] frameLen;
    logic [AW-1:0] rdAddr;
    logic [7:0]    rdData;
    logic          frameErr;
    logic [2:0]    errCode;
    logic          busy;

    modport master (
        output byteValid, byteIn, byteErr, frameAck, rdAddr,
        input  frameValid, frameLen, rdData, frameErr, errCode, busy
    );

    modport slave (
        input  byteValid, byteIn, byteErr, frameAck, rdAddr,
        output frameValid, frameLen, rdData, frameErr, errCode, busy
    );
endinterface

// File: rtl/uart_frame_decoder.sv
// Decodes SYNC/LEN/payload/CHK frames from the UART byte stream into a payload buffer
// with length and checksum verification, inter-byte timeout and a valid/ack handshake.
module uart_frame_decoder #(
    parameter int         MAX_PAYLOAD    = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 200000,
    parameter int         LW             = $clog2(MAX_PAYLOAD + 1),
    parameter int         AW             = $clog2(MAX_PAYLOAD)
) (
    input  logic                clk,
    input  logic                rst,
    uart_frame_decoder_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_CHK     = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_LINE    = 3'd4;
    localparam logic [2:0] ERR_OVERRUN = 3'd5;

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_idx;
    logic [7:0]    r_acc;
    logic [7:0]    r_buf [MAX_PAYLOAD];

    logic          r_fv;
    logic          r_ferr;
    logic          r_busy;
    logic [2:0]    r_code;

    logic          w_err;
    logic [2:0]    w_code;
    logic          w_sync;
    logic          w_len_ok;
    logic          w_tmo;
    logic          w_load;
    logic          w_wr;
    logic          w_rd_ok;

    assign w_sync   = bus.byteValid && (bus.byteIn == SYNC_BYTE);
    assign w_len_ok = (bus.byteIn != 8'h00) && (int'(bus.byteIn) <= MAX_PAYLOAD);
    // A byte landing on the expiry cycle beats the timeout.
    assign w_tmo    = (r_cnt == CW'(TIMEOUT_CYCLES - 1)) && !bus.byteValid;
    assign w_rd_ok  = int'(bus.rdAddr) < MAX_PAYLOAD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        w_code = '0;
        unique case (r_state)
            S_HUNT: begin
                if (w_sync) begin
                    w_next = S_LEN;
                end
            end
            S_LEN: begin
                if (bus.byteErr) begin
                    w_next = S_HUNT;
                    w_err  = 1'b1;
                    w_code = ERR_LINE;
                end else if (bus.byteValid) begin
                    if (w_len_ok) begin
                        w_next = S_PAYLOAD;
                    end else begin
                        w_next = S_HUNT;
                        w_err  = 1'b1;
                        w_code = ERR_LEN;
                    end
                end else if (w_tmo) begin
                    w_next = S_HUNT;
                    w_err  = 1'b1;
                    w_code = ERR_TIMEOUT;
                end
            end
            S_PAYLOAD: begin
                if (bus.byteErr) begin
                    w_next = S_HUNT;
                    w_err  = 1'b1;
                    w_code = ERR_LINE;
                end else if (bus.byteValid) begin
                    if (r_idx == r_len - LW'(1)) begin
                        w_next = S_CHECK;
                    end
                end else if (w_tmo) begin
                    w_next = S_HUNT;
                    w_err  = 1'b1;
                    w_code = ERR_TIMEOUT;
                end
            end
            S_CHECK: begin
                if (bus.byteErr) begin
                    w_next = S_HUNT;
                    w_err  = 1'b1;
                    w_code = ERR_LINE;
                end else if (bus.byteValid) begin
                    if (bus.byteIn == r_acc) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_HUNT;
                        w_err  = 1'b1;
                        w_code = ERR_CHK;
                    end
                end else if (w_tmo) begin
                    w_next = S_HUNT;
                    w_err  = 1'b1;
                    w_code = ERR_TIMEOUT;
                end
            end
            S_DONE: begin
                // Ack releases the buffer this cycle, so a coincident byte is judged as in HUNT.
                if (bus.frameAck) begin
                    w_next = w_sync ? S_LEN : S_HUNT;
                end else if (bus.byteValid) begin
                    w_err  = 1'b1;
                    w_code = ERR_OVERRUN;
                end
            end
            default: begin
                w_next = S_HUNT;
            end
        endcase
    end

    always_comb begin
        w_load     = 1'b0;
        w_wr       = 1'b0;
        w_cnt_next = '0;
        if (bus.byteValid && !bus.byteErr) begin
            w_load = (r_state == S_LEN) && w_len_ok;
            w_wr   = (r_state == S_PAYLOAD);
        end
        if ((r_state inside {S_LEN, S_PAYLOAD, S_CHECK}) && (w_next == r_state) && !bus.byteValid) begin
            w_cnt_next = r_cnt + CW'(1);
        end
        bus.rdData = w_rd_ok ? r_buf[bus.rdAddr] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_len  <= '0;
            r_idx  <= '0;
            r_acc  <= '0;
            r_fv   <= 1'b0;
            r_ferr <= 1'b0;
            r_busy <= 1'b0;
            r_code <= '0;
            for (int unsigned i = 0; i < MAX_PAYLOAD; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_cnt  <= w_cnt_next;
            r_fv   <= (w_next == S_DONE);
            r_busy <= (w_next != S_HUNT);
            r_ferr <= w_err;
            if (w_err) begin
                r_code <= w_code;
            end
            if (w_load) begin
                r_len <= bus.byteIn[LW-1:0];
                r_acc <= bus.byteIn;
                r_idx <= '0;
            end
            if (w_wr) begin
                r_buf[r_idx[AW-1:0]] <= bus.byteIn;
                r_acc                <= r_acc + bus.byteIn;
                r_idx                <= r_idx + LW'(1);
            end
        end
    end

    assign bus.frameValid = r_fv;
    assign bus.frameLen   = r_len;
    assign bus.frameErr   = r_ferr;
    assign bus.errCode    = r_code;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder: directed vector table, timing corner
// sequences and random frames checked against a frame-level reference model.
module tb_uart_frame_decoder;
    localparam int MAXP = 16;
    localparam int T    = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_frame_decoder_if #(.MAX_PAYLOAD(MAXP)) bus ();

    uart_frame_decoder #(
        .MAX_PAYLOAD   (MAXP),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string        name;
        logic [159:0] bytes;
        int           n;
        bit           exp_valid;
        int           exp_len;
        logic [127:0] exp_data;
        int           exp_code;
    } vec_t;

    vec_t       vec [7];
    logic [7:0] pl [MAXP];
    int total  = 0;
    int bad    = 0;
    int pulses = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.frameErr) pulses++;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bus.byteValid = 1'b1;
        bus.byteIn    = b;
        tick();
        bus.byteValid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic rd(input string name, input int idx, input logic [7:0] exp);
        bus.rdAddr = 4'(idx);
        #1;
        chk(name, int'(bus.rdData), int'(exp));
    endtask

    task automatic expect_frame(input string name, input int len);
        chk({name, "_valid"}, int'(bus.frameValid), 1);
        chk({name, "_len"}, int'(bus.frameLen), len);
        for (int i = 0; i < len; i++) rd({name, "_data"}, i, pl[i]);
    endtask

    task automatic do_ack(input string name);
        bus.frameAck = 1'b1;
        tick();
        bus.frameAck = 1'b0;
        chk({name, "_ack_valid"}, int'(bus.frameValid), 0);
        chk({name, "_ack_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int exp_code;
        int len;
        int sum;
        int kind;
        logic [7:0] b;
        logic [7:0] chkb;

        bus.byteValid = 1'b0;
        bus.byteIn    = '0;
        bus.byteErr   = 1'b0;
        bus.frameAck  = 1'b0;
        bus.rdAddr    = '0;

        vec[0] = '{"basic",   160'hA50311223369,  6, 1'b1,  3, 128'h112233, 0};
        vec[1] = '{"badchk",  160'hA502102000,    5, 1'b0,  0, 128'h0,      2};
        vec[2] = '{"after",   160'hA5017E7F,      4, 1'b1,  1, 128'h7E,     2};
        vec[3] = '{"len0",    160'hA500,          2, 1'b0,  0, 128'h0,      1};
        vec[4] = '{"len17",   160'hA511,          2, 1'b0,  0, 128'h0,      1};
        vec[5] = '{"len16",   160'hA510_01010101010101010101010101010101_20, 19, 1'b1, 16,
                   128'h01010101010101010101010101010101, 1};
        vec[6] = '{"huntsync", 160'h00FFA501A5A6, 6, 1'b1,  1, 128'hA5,     1};

        #1;
        chk("reset_valid", int'(bus.frameValid), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_len", int'(bus.frameLen), 0);
        chk("reset_err", int'(bus.frameErr), 0);
        chk("reset_code", int'(bus.errCode), 0);
        chk("reset_rd", int'(bus.rdData), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            pulses = 0;
            for (int k = 0; k < vec[v].n; k++)
                send(vec[v].bytes[8*(vec[v].n-1-k) +: 8], (k == vec[v].n - 1) ? 0 : 1);
            if (vec[v].exp_valid) begin
                for (int i = 0; i < vec[v].exp_len; i++)
                    pl[i] = vec[v].exp_data[8*(vec[v].exp_len-1-i) +: 8];
                expect_frame(vec[v].name, vec[v].exp_len);
            end else begin
                chk({vec[v].name, "_strobe"}, int'(bus.frameErr), 1);
                chk({vec[v].name, "_busy"}, int'(bus.busy), 0);
            end
            chk({vec[v].name, "_code"}, int'(bus.errCode), vec[v].exp_code);
            repeat (2) tick();
            chk({vec[v].name, "_pulses"}, pulses, vec[v].exp_valid ? 0 : 1);
            if (vec[v].exp_valid) do_ack(vec[v].name);
        end
        exp_code = 1;

        // Byte arriving exactly on the expiry cycle is accepted.
        pulses = 0;
        send(8'hA5, 1); send(8'h02, 1); send(8'h10, 0);
        repeat (T - 1) tick();
        send(8'h20, 1);
        send(8'h32, 0);
        pl[0] = 8'h10; pl[1] = 8'h20;
        expect_frame("late", 2);
        chk("late_pulses", pulses, 0);
        do_ack("late");

        // Idle gap after a payload byte times out.
        pulses = 0;
        send(8'hA5, 1); send(8'h02, 1); send(8'h10, 0);
        repeat (T - 1) tick();
        chk("tmo_early_err", int'(bus.frameErr), 0);
        chk("tmo_early_busy", int'(bus.busy), 1);
        tick();
        chk("tmo_err", int'(bus.frameErr), 1);
        chk("tmo_code", int'(bus.errCode), 3);
        chk("tmo_busy", int'(bus.busy), 0);
        tick();
        chk("tmo_pulse_end", int'(bus.frameErr), 0);
        exp_code = 3;

        // Overrun while a frame is held, then ack racing a SYNC byte.
        send(8'hA5, 1); send(8'h02, 1); send(8'h10, 1); send(8'h20, 1); send(8'h32, 1);
        send(8'h55, 0);
        chk("ovr_err", int'(bus.frameErr), 1);
        chk("ovr_code", int'(bus.errCode), 5);
        pl[0] = 8'h10; pl[1] = 8'h20;
        expect_frame("ovr_hold", 2);
        tick();
        bus.frameAck = 1'b1;
        send(8'hA5, 0);
        bus.frameAck = 1'b0;
        chk("race_valid", int'(bus.frameValid), 0);
        chk("race_busy", int'(bus.busy), 1);
        send(8'h01, 1); send(8'h09, 1); send(8'h0A, 0);
        pl[0] = 8'h09;
        expect_frame("race", 1);
        do_ack("race");
        exp_code = 5;

        // Random frames against a frame-level model.
        for (int f = 0; f < 30; f++) begin
            pulses = 0;
            kind = $urandom_range(0, 9);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                b = 8'($urandom_range(0, 254));
                if (b >= 8'hA5) b = b + 8'd1;
                send(b, $urandom_range(0, 3));
            end
            send(8'hA5, $urandom_range(0, 3));
            if (kind == 9) begin
                len = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAXP + 1, 255);
                send(8'(len), 0);
                chk("rnd_badlen_err", int'(bus.frameErr), 1);
                exp_code = 1;
            end else begin
                len = $urandom_range(1, MAXP);
                sum = len;
                send(8'(len), $urandom_range(0, 3));
                for (int i = 0; i < len; i++) begin
                    pl[i] = 8'($urandom_range(0, 255));
                    sum += int'(pl[i]);
                    send(pl[i], $urandom_range(0, 3));
                end
                chkb = 8'(sum % 256);
                if (kind >= 7) chkb = chkb + 8'($urandom_range(1, 255));
                send(chkb, 0);
                if (kind >= 7) begin
                    chk("rnd_badchk_err", int'(bus.frameErr), 1);
                    chk("rnd_badchk_valid", int'(bus.frameValid), 0);
                    exp_code = 2;
                end else begin
                    expect_frame("rnd", len);
                end
            end
            chk("rnd_code", int'(bus.errCode), exp_code);
            repeat (2) tick();
            chk("rnd_pulses", pulses, (kind >= 7) ? 1 : 0);
            if (kind < 7) do_ack("rnd");
        end

        // Line error wins over a simultaneous byte.
        send(8'hA5, 1); send(8'h03, 1); send(8'h11, 1);
        bus.byteErr   = 1'b1;
        bus.byteValid = 1'b1;
        bus.byteIn    = 8'h22;
        tick();
        bus.byteErr   = 1'b0;
        bus.byteValid = 1'b0;
        chk("line_err", int'(bus.frameErr), 1);
        chk("line_code", int'(bus.errCode), 4);
        chk("line_busy", int'(bus.busy), 0);

        // Asynchronous reset mid-payload.
        send(8'hA5, 1); send(8'h03, 1); send(8'h11, 1);
        bus.rdAddr = '0;
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_valid", int'(bus.frameValid), 0);
        chk("arst_len", int'(bus.frameLen), 0);
        chk("arst_code", int'(bus.errCode), 0);
        chk("arst_err", int'(bus.frameErr), 0);
        chk("arst_rd", int'(bus.rdData), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        send(8'hA5, 1); send(8'h03, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
        send(8'h69, 0);
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        expect_frame("post_rst", 3);
        chk("post_rst_code", int'(bus.errCode), 0);
        do_ack("post_rst");
        chk("post_rst_pulses", pulses, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
